// File: rtl/cpu_load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_load_store_unit_if
// Brief    : Pipeline-side and data-cache-side signals of the load/store unit.
// Revision : 1.0
// ============================================================================
interface cpu_load_store_unit_if;
    // Pipeline side
    logic        i_request;
    logic        i_rw;
    logic [1:0]  i_width;
    logic        i_signed;
    logic        i_flush;
    logic        i_cacheable;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_fault;
    logic [31:0] o_rdata;
    // Data cache side
    logic        o_dc_request;
    logic        o_dc_rw;
    logic        o_dc_flush;
    logic        o_dc_cacheable;
    logic [31:0] o_dc_address;
    logic [31:0] o_dc_wdata;
    logic        i_dc_ready;
    logic [31:0] i_dc_rdata;

    // master: the surrounding pipeline and cache; slave: the load/store unit
    modport master (
        output i_request, i_rw, i_width, i_signed, i_flush, i_cacheable,
               i_address, i_wdata, i_dc_ready, i_dc_rdata,
        input  o_ready, o_fault, o_rdata, o_dc_request, o_dc_rw, o_dc_flush,
               o_dc_cacheable, o_dc_address, o_dc_wdata
    );

    modport slave (
        input  i_request, i_rw, i_width, i_signed, i_flush, i_cacheable,
               i_address, i_wdata, i_dc_ready, i_dc_rdata,
        output o_ready, o_fault, o_rdata, o_dc_request, o_dc_rw, o_dc_flush,
               o_dc_cacheable, o_dc_address, o_dc_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_load_store_unit
// Brief    : Byte/half/word loads and stores onto a word-only data cache,
//            with read-modify-write for sub-word stores and flush forwarding.
// Revision : 1.0
// ============================================================================
module cpu_load_store_unit #(
    parameter int RESET_STATE_IDLE = 1
) (
    input wire                   i_clock,
    input wire                   i_reset,
    cpu_load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        c_st_idle     = 3'd0,
        c_st_read     = 3'd1,
        c_st_rmw_read = 3'd2,
        c_st_rmw_gap  = 3'd3,
        c_st_write    = 3'd4,
        c_st_flush    = 3'd5,
        c_st_done     = 3'd6,
        c_st_fault    = 3'd7
    } state_t;

    // IDLE is the only supported reset state.
    localparam state_t c_reset_state = (RESET_STATE_IDLE == 1) ? c_st_idle : c_st_idle;

    state_t      r_state;
    logic [1:0]  r_width;
    logic        r_signed;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;
    logic [31:0] r_word;

    logic        r_ready;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic        r_dc_request;
    logic        r_dc_rw;
    logic        r_dc_flush;
    logic        r_dc_cacheable;
    logic [31:0] r_dc_address;
    logic [31:0] r_dc_wdata;

    logic        w_misaligned;

    assign w_misaligned = (bus.i_width == 2'd3) ||
                          ((bus.i_width == 2'd1) && bus.i_address[0]) ||
                          ((bus.i_width == 2'd2) && (bus.i_address[1:0] != 2'b00));

    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  width,
                                              input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            2'd0:    res = {{24{sgn & b[7]}}, b};
            2'd1:    res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [1:0]  off,
                                            input logic [1:0]  width,
                                            input logic [15:0] data);
        logic [31:0] res;
        res = old;
        if (width == 2'd0) begin
            case (off)
                2'd0:    res[7:0]   = data[7:0];
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                default: res[31:24] = data[7:0];
            endcase
        end else if (off[1]) begin
            res[31:16] = data;
        end else begin
            res[15:0] = data;
        end
        return res;
    endfunction

    // Outputs are set on the transition into each state so they are pure flops.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= c_reset_state;
            r_width        <= 2'd0;
            r_signed       <= 1'b0;
            r_offset       <= 2'd0;
            r_wdata        <= 16'd0;
            r_word         <= 32'd0;
            r_ready        <= 1'b0;
            r_fault        <= 1'b0;
            r_rdata        <= 32'd0;
            r_dc_request   <= 1'b0;
            r_dc_rw        <= 1'b0;
            r_dc_flush     <= 1'b0;
            r_dc_cacheable <= 1'b0;
            r_dc_address   <= 32'd0;
            r_dc_wdata     <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.i_request) begin
                        r_width        <= bus.i_width;
                        r_signed       <= bus.i_signed;
                        r_offset       <= bus.i_address[1:0];
                        r_wdata        <= bus.i_wdata[15:0];
                        r_dc_address   <= {bus.i_address[31:2], 2'b00};
                        r_dc_cacheable <= bus.i_cacheable;
                        if (bus.i_flush) begin
                            r_state      <= c_st_flush;
                            r_dc_request <= 1'b1;
                            r_dc_flush   <= 1'b1;
                            r_dc_rw      <= 1'b0;
                        end else if (w_misaligned) begin
                            r_state <= c_st_fault;
                            r_fault <= 1'b1;
                        end else if (!bus.i_rw) begin
                            r_state      <= c_st_read;
                            r_dc_request <= 1'b1;
                            r_dc_rw      <= 1'b0;
                        end else if (bus.i_width == 2'd2) begin
                            r_state      <= c_st_write;
                            r_dc_request <= 1'b1;
                            r_dc_rw      <= 1'b1;
                            r_dc_wdata   <= bus.i_wdata;
                        end else begin
                            r_state      <= c_st_rmw_read;
                            r_dc_request <= 1'b1;
                            r_dc_rw      <= 1'b0;
                        end
                    end
                end
                c_st_read: begin
                    if (bus.i_dc_ready) begin
                        r_word       <= bus.i_dc_rdata;
                        r_rdata      <= f_extract(bus.i_dc_rdata, r_offset, r_width, r_signed);
                        r_ready      <= 1'b1;
                        r_dc_request <= 1'b0;
                        r_state      <= c_st_done;
                    end
                end
                c_st_rmw_read: begin
                    if (bus.i_dc_ready) begin
                        r_word       <= bus.i_dc_rdata;
                        r_dc_request <= 1'b0;
                        r_state      <= c_st_rmw_gap;
                    end
                end
                c_st_rmw_gap: begin
                    // One request-low cycle lets an uncached access retire first.
                    r_dc_wdata   <= f_merge(r_word, r_offset, r_width, r_wdata);
                    r_dc_request <= 1'b1;
                    r_dc_rw      <= 1'b1;
                    r_state      <= c_st_write;
                end
                c_st_write: begin
                    if (bus.i_dc_ready) begin
                        r_dc_request <= 1'b0;
                        r_dc_rw      <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= c_st_done;
                    end
                end
                c_st_flush: begin
                    if (bus.i_dc_ready) begin
                        r_dc_request <= 1'b0;
                        r_dc_flush   <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_ready <= 1'b0;
                    r_rdata <= 32'd0;
                    r_state <= c_st_idle;
                end
                c_st_fault: begin
                    r_fault <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.o_ready        = r_ready;
    assign bus.o_fault        = r_fault;
    assign bus.o_rdata        = r_rdata;
    assign bus.o_dc_request   = r_dc_request;
    assign bus.o_dc_rw        = r_dc_rw;
    assign bus.o_dc_flush     = r_dc_flush;
    assign bus.o_dc_cacheable = r_dc_cacheable;
    assign bus.o_dc_address   = r_dc_address;
    assign bus.o_dc_wdata     = r_dc_wdata;

endmodule
`default_nettype wire
